// File: rtl/pe_slice_sequencer.sv
// Multi-precision slice sequencer for one PE adder tree: issues every (weight, activation)
// slice pair, accumulates the returned partial sums with their slice shifts, and hands off one result.
module pe_slice_sequencer #(
  parameter int unsigned SUM_W   = 10,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned SLICE_W = 2,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] w_prec,
  input  logic [IDX_W-1:0] a_prec,
  output logic             busy,
  output logic             issue_vld,
  input  logic             issue_rdy,
  output logic [IDX_W-1:0] w_idx,
  output logic [IDX_W-1:0] a_idx,
  output logic             w_msb,
  output logic             a_msb,
  input  logic             sum_vld,
  input  logic [SUM_W-1:0] pe_sum,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [ACC_W-1:0] result,
  output logic             err_stray
);

  // Enough to count every pair of the widest pass.
  localparam int unsigned CNT_W = 2 * IDX_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] w_prec_q, w_prec_d, a_prec_q, a_prec_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d, a_idx_q, a_idx_d;
  logic [IDX_W-1:0] ret_w_q, ret_w_d, ret_a_q, ret_a_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, result_q, result_d;
  logic             err_stray_q, err_stray_d;

  logic             fire, last_issue, active, sum_take;
  logic [IDX_W:0]   ret_sum;
  int unsigned      shamt;
  logic [ACC_W-1:0] sum_ext;

  assign issue_vld  = (state_q == StIssue);
  assign fire       = issue_vld & issue_rdy;
  assign last_issue = (w_idx_q == w_prec_q) && (a_idx_q == a_prec_q);
  assign active     = (state_q == StIssue) || (state_q == StDrain);
  // A sum returned alongside its own issue transfer is legitimate.
  assign sum_take   = sum_vld && active && ((out_cnt_q != '0) || fire);

  assign ret_sum = {1'b0, ret_w_q} + {1'b0, ret_a_q};
  assign shamt   = SLICE_W * 32'(ret_sum);
  assign sum_ext = {{(ACC_W - SUM_W){pe_sum[SUM_W-1]}}, pe_sum};

  always_comb begin
    state_d     = state_q;
    w_prec_d    = w_prec_q;
    a_prec_d    = a_prec_q;
    w_idx_d     = w_idx_q;
    a_idx_d     = a_idx_q;
    ret_w_d     = ret_w_q;
    ret_a_d     = ret_a_q;
    out_cnt_d   = out_cnt_q + CNT_W'(fire) - CNT_W'(sum_take);
    acc_d       = acc_q;
    result_d    = result_q;
    err_stray_d = sum_vld && !sum_take;

    if (sum_take) begin
      acc_d = acc_q + (sum_ext << shamt);
      if (ret_a_q == a_prec_q) begin
        ret_a_d = '0;
        ret_w_d = ret_w_q + 1'b1;
      end else begin
        ret_a_d = ret_a_q + 1'b1;
      end
    end

    if (fire && !last_issue) begin
      if (a_idx_q == a_prec_q) begin
        a_idx_d = '0;
        w_idx_d = w_idx_q + 1'b1;
      end else begin
        a_idx_d = a_idx_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StIssue;
          w_prec_d  = w_prec;
          a_prec_d  = a_prec;
          w_idx_d   = '0;
          a_idx_d   = '0;
          ret_w_d   = '0;
          ret_a_d   = '0;
          out_cnt_d = '0;
          acc_d     = '0;
        end
      end
      StIssue: begin
        if (fire && last_issue) state_d = StDrain;
      end
      StDrain: begin
        // out_cnt_q is zero only once the final sum has already landed in acc_q.
        if (out_cnt_q == '0) begin
          state_d  = StDone;
          result_d = acc_q;
        end
      end
      StDone: begin
        if (res_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      w_prec_q    <= '0;
      a_prec_q    <= '0;
      w_idx_q     <= '0;
      a_idx_q     <= '0;
      ret_w_q     <= '0;
      ret_a_q     <= '0;
      out_cnt_q   <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_prec_q    <= w_prec_d;
      a_prec_q    <= a_prec_d;
      w_idx_q     <= w_idx_d;
      a_idx_q     <= a_idx_d;
      ret_w_q     <= ret_w_d;
      ret_a_q     <= ret_a_d;
      out_cnt_q   <= out_cnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      err_stray_q <= err_stray_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign res_vld   = (state_q == StDone);
  assign w_idx     = w_idx_q;
  assign a_idx     = a_idx_q;
  assign w_msb     = (w_idx_q == w_prec_q);
  assign a_msb     = (a_idx_q == a_prec_q);
  assign result    = result_q;
  assign err_stray = err_stray_q;

endmodule

// File: tb/tb_pe_slice_sequencer.sv
// Bench for pe_slice_sequencer: pair-list/result model checked every cycle plus literal pins.
module tb_pe_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, issue_rdy, sum_vld, res_rdy;
  logic [1:0]  w_prec, a_prec, w_idx, a_idx;
  logic [9:0]  pe_sum;
  logic        busy, issue_vld, w_msb, a_msb, res_vld, err_stray;
  logic [31:0] result;

  pe_slice_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .w_prec(w_prec), .a_prec(a_prec), .busy(busy),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy), .w_idx(w_idx), .a_idx(a_idx),
    .w_msb(w_msb), .a_msb(a_msb), .sum_vld(sum_vld), .pe_sum(pe_sum), .res_vld(res_vld),
    .res_rdy(res_rdy), .result(result), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model state
  typedef struct {int w; int a; int wp; int ap;} iss_t;
  int                 sum_tab[16];
  iss_t               exp_iss[$];
  int                 pe_q[$];
  logic signed [31:0] exp_res, cap_res;
  bit                 in_pass, stray_prev, armed, hs_done, prev_stall, prev_resv;
  int                 outstanding, n_issued;
  logic [1:0]         prev_w, prev_a;
  logic [31:0]        prev_res;

  always @(negedge clk) begin
    bit   was_in_pass, stray_now;
    iss_t e;
    if (rst) begin
      in_pass = 0; outstanding = 0; stray_prev = 0; prev_stall = 0; prev_resv = 0;
      n_issued = 0; armed = 1;
      exp_iss.delete();
      pe_q.delete();
    end else if (armed) begin
      was_in_pass = in_pass;
      chk("busy", busy, in_pass);
      chk("err_stray", err_stray, stray_prev);
      chk("issue_in_pass", issue_vld && !in_pass, 0);
      if (prev_stall) begin
        chk("hold_vld", issue_vld, 1);
        chk("hold_w_idx", w_idx, prev_w);
        chk("hold_a_idx", a_idx, prev_a);
      end
      if (issue_vld && issue_rdy) begin
        if (exp_iss.size() == 0) begin
          chk("extra_issue", issue_vld, 0);
        end else begin
          e = exp_iss.pop_front();
          chk("w_idx", w_idx, e.w);
          chk("a_idx", a_idx, e.a);
          chk("w_msb", w_msb, e.w == e.wp);
          chk("a_msb", a_msb, e.a == e.ap);
          pe_q.push_back(sum_tab[n_issued]);
          n_issued++;
          outstanding++;
        end
      end
      stray_now = sum_vld && (outstanding == 0);
      if (sum_vld && !stray_now) outstanding--;
      if (res_vld) begin
        chk("result", $signed(result), exp_res);
        chk("res_early", (exp_iss.size() != 0) || (outstanding != 0), 0);
        if (prev_resv) chk("res_hold", result, prev_res);
        if (res_rdy) begin
          in_pass = 0;
          hs_done = 1;
          cap_res = result;
        end
      end
      if (start && !was_in_pass) begin
        int k;
        in_pass  = 1;
        n_issued = 0;
        exp_res  = '0;
        k        = 0;
        for (int w = 0; w <= int'(w_prec); w++) begin
          for (int a = 0; a <= int'(a_prec); a++) begin
            exp_iss.push_back('{w, a, int'(w_prec), int'(a_prec)});
            exp_res = exp_res + (sum_tab[k] <<< (2 * (w + a)));
            k++;
          end
        end
      end
      prev_stall = issue_vld && !issue_rdy;
      prev_w     = w_idx;
      prev_a     = a_idx;
      prev_resv  = res_vld;
      prev_res   = result;
      stray_prev = stray_now;
    end
  end

  // PE stand-in: each accepted issue returns its sum one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    if (pe_q.size() > 0) begin
      sum_vld = 1'b1;
      pe_sum  = 10'(pe_q.pop_front());
    end else begin
      sum_vld = 1'b0;
      pe_sum  = '0;
    end
  endtask

  task automatic chk_reset();
    chk("rst_busy", busy, 0);
    chk("rst_issue_vld", issue_vld, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_err_stray", err_stray, 0);
    chk("rst_w_idx", w_idx, 0);
    chk("rst_a_idx", a_idx, 0);
    chk("rst_result", result, 0);
  endtask

  task automatic run_pass(input int wp, input int ap, input int stall_at, input int stall_len,
                          input int hold, input bit poke, output int lat,
                          output logic signed [31:0] res);
    int stalled, hold_cnt;
    bit seen;
    w_prec  = 2'(wp);
    a_prec  = 2'(ap);
    start   = 1'b1;
    hs_done = 0;
    res_rdy = (hold == 0);
    step();
    start   = 1'b0;
    w_prec  = 2'(wp + 1);
    lat = 0; stalled = 0; hold_cnt = 0; seen = 0;
    for (int c = 0; c < 400 && !hs_done; c++) begin
      step();
      if (!seen) begin
        lat++;
        if (res_vld) seen = 1;
      end
      if (issue_vld && n_issued == stall_at && stalled < stall_len) begin
        issue_rdy = 1'b0;
        stalled++;
      end else begin
        issue_rdy = 1'b1;
      end
      start  = poke && (c == 1);
      a_prec = poke && (c == 1) ? 2'd3 : 2'(ap);
      if (seen && hold > 0) begin
        if (hold_cnt == 1) begin
          sum_vld = 1'b1;
          pe_sum  = 10'd9;
        end
        if (hold_cnt < hold) begin
          res_rdy = 1'b0;
          hold_cnt++;
        end else begin
          res_rdy = 1'b1;
        end
      end
    end
    chk("pass_done", hs_done, 1);
    start   = 1'b0;
    res_rdy = 1'b1;
    res     = cap_res;
  endtask

  initial begin
    int                 lat;
    logic signed [31:0] res;
    rst = 1'b1; start = 1'b0; w_prec = '0; a_prec = '0; issue_rdy = 1'b1;
    sum_vld = 1'b0; pe_sum = '0; res_rdy = 1'b1;
    repeat (2) step();
    chk_reset();
    rst = 1'b0;
    step();

    // T1: single pair
    sum_tab[0] = -5;
    run_pass(0, 0, -1, 0, 0, 0, lat, res);
    chk("t1_latency", lat, 3);
    chk("t1_result", res, -5);

    // T2: 2x2 pairs, start/prec pokes mid-pass are ignored
    sum_tab[0] = 1; sum_tab[1] = 2; sum_tab[2] = 3; sum_tab[3] = 4;
    run_pass(1, 1, -1, 0, 0, 1, lat, res);
    chk("t2_latency", lat, 6);
    chk("t2_result", res, 85);

    // T3: second issue stalled two cycles
    run_pass(1, 1, 1, 2, 0, 0, lat, res);
    chk("t3_latency", lat, 8);
    chk("t3_result", res, 85);

    // T4: 4x4 pairs of -1, result held three cycles with a stray sum in between
    for (int i = 0; i < 16; i++) sum_tab[i] = -1;
    run_pass(3, 3, -1, 0, 3, 0, lat, res);
    chk("t4_latency", lat, 18);
    chk("t4_issues", n_issued, 16);
    chk("t4_result", res, -7225);

    // T5: stray sum while idle, then a clean pass
    step();
    sum_vld = 1'b1;
    pe_sum  = 10'd7;
    step();
    step();
    sum_tab[0] = -5;
    run_pass(0, 0, -1, 0, 0, 0, lat, res);
    chk("t5_result", res, -5);

    // T6: reset on the third issue of a 2x2 pass
    sum_tab[0] = 1; sum_tab[1] = 2; sum_tab[2] = 3; sum_tab[3] = 4;
    w_prec = 2'd1; a_prec = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 50 && !(n_issued == 2 && issue_vld); c++) step();
    chk("t6_reach_third", n_issued, 2);
    rst = 1'b1;
    step();
    chk_reset();
    rst     = 1'b0;
    sum_vld = 1'b1;
    pe_sum  = 10'd3;
    step();
    step();
    sum_tab[0] = -5;
    run_pass(0, 0, -1, 0, 0, 0, lat, res);
    chk("t6_result", res, -5);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
